// File: rtl/wsb_pkg.sv
// Shared types and constants for the weight stream buffer: FSM states, output FIFO
// sizing, credit width and bit-placement helpers.
package wsb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } wsb_state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int CREDIT_W   = CNT_W;

  // One credit per FIFO slot, so issued-but-unpopped reads can never overflow it.
  localparam logic [CREDIT_W-1:0] CREDITS_FULL = CREDIT_W'(FIFO_DEPTH);

  // Bit offset of lane `lane` of bank `bank` inside a packed beat.
  function automatic int lane_offset(input int bank, input int lane,
                                     input int lanes, input int data_w);
    return (bank * lanes + lane) * data_w;
  endfunction

  // Reference contents of a read-only bank: lane value encodes bank, word and lane.
  function automatic int init_lane(input int bank, input int idx, input int lane);
    return (bank << 12) | (idx << 4) | lane;
  endfunction

endpackage

// File: rtl/wsb_bank_ram.sv
// One weight bank: synchronous single port, registered read data, write wins over read.
// With WSB_LOAD_EN the bank is writable RAM; otherwise it is a constant ROM.
module wsb_bank_ram
  import wsb_pkg::*;
#(
  parameter int DATA_W  = 18,
  parameter int LANES   = 9,
  parameter int DEPTH   = 42,
  parameter int IDX_W   = 12,
  parameter int BANK_ID = 0
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        addr,
  input  logic [LANES*DATA_W-1:0] wdata,
  output logic [LANES*DATA_W-1:0] rdata
);

  localparam int WORD_W = LANES * DATA_W;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

  logic in_range;
  assign in_range = (addr < DEPTH_I);

`ifdef WSB_LOAD_EN
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      if (in_range) mem[addr[AW-1:0]] <= wdata;
    end else begin
      rdata <= in_range ? mem[addr[AW-1:0]] : '0;
    end
  end
`else
  function automatic logic [WORD_W-1:0] rom_word(input logic [IDX_W-1:0] a);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++)
      w[lane_offset(0, l, LANES, DATA_W) +: DATA_W] = DATA_W'(init_lane(BANK_ID, int'(a), l));
    return w;
  endfunction

  logic unused_wr;
  assign unused_wr = we ^ (^wdata);

  always_ff @(posedge clk) begin
    rdata <= in_range ? rom_word(addr) : '0;
  end
`endif

endmodule

// File: rtl/weight_stream_buffer.sv
// Streams BANKS-wide packed weight beats under a start/length command with ready/valid
// backpressure through a credit-controlled 4-entry FIFO. WSB_LOAD_EN enables the load port.
module weight_stream_buffer
  import wsb_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int LANES  = 9,
  parameter int BANKS  = 2,
  parameter int DEPTH  = 42,
  parameter int IDX_W  = 12
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [IDX_W-1:0]                       base_index,
  input  logic [IDX_W-1:0]                       len,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [BANKS*LANES*DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]                       out_index,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done,
  input  logic                                   load_valid,
  output logic                                   load_ready,
  input  logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] load_bank,
  input  logic [IDX_W-1:0]                       load_addr,
  input  logic [LANES*DATA_W-1:0]                load_data
);

  localparam int WORD_W = LANES * DATA_W;
  localparam int BEAT_W = BANKS * WORD_W;
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] DEPTH_I  = IDX_W'(DEPTH);

  wsb_state_e          state;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    remaining;
  logic [CREDIT_W-1:0] credits;

  // Read stage: metadata of the read whose RAM data is registered this cycle.
  logic                s1_valid;
  logic                s1_last;
  logic [IDX_W-1:0]    s1_idx;

  logic [BEAT_W-1:0]   ram_rdata;
  logic [IDX_W-1:0]    ram_addr;

  logic [BEAT_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [IDX_W-1:0]    fifo_idx  [FIFO_DEPTH];
  logic                fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  logic issue, pop, start_go, drain_done, next_idle;
  logic load_fire, load_in_range;

  assign issue      = (state == STREAM) && (credits != '0);
  assign pop        = out_valid && out_ready;
  assign start_go   = (state == IDLE) && start && (len != '0);
  // The tagged last beat leaving the FIFO means nothing is queued or in flight behind it.
  assign drain_done = (state == DRAIN) && pop && out_last;
  assign next_idle  = ((state == IDLE) && !start_go) || drain_done;

  assign load_in_range = (load_addr < DEPTH_I);

`ifdef WSB_LOAD_EN
  assign load_fire = load_valid && load_ready && (state == IDLE) && !start;

  always_ff @(posedge clk) begin
    if (reset) load_ready <= 1'b0;
    else       load_ready <= next_idle;
  end
`else
  logic unused_load;
  assign unused_load = load_valid;
  assign load_fire   = 1'b0;
  assign load_ready  = 1'b0;
`endif

  assign ram_addr = load_fire ? load_addr : rd_idx;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic bank_we;
    assign bank_we = load_fire && load_in_range && (load_bank == BANK_W'(b));

    wsb_bank_ram #(
      .DATA_W  (DATA_W),
      .LANES   (LANES),
      .DEPTH   (DEPTH),
      .IDX_W   (IDX_W),
      .BANK_ID (b)
    ) u_ram (
      .clk   (clk),
      .we    (bank_we),
      .addr  (ram_addr),
      .wdata (load_data),
      .rdata (ram_rdata[lane_offset(b, 0, LANES, DATA_W) +: WORD_W])
    );
  end

  // NOTE: every register in a clocked block is assigned with <= so all of them
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_idx    <= '0;
      remaining <= '0;
      credits   <= CREDITS_FULL;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_idx    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      s1_valid <= issue;
      if (issue) begin
        s1_idx  <= rd_idx;
        s1_last <= (remaining == IDX_W'(1));
      end

      credits <= credits - CREDIT_W'(issue) + CREDIT_W'(pop);
      count   <= count + CNT_W'(s1_valid) - CNT_W'(pop);
      if (s1_valid) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);

      case (state)
        IDLE: begin
          if (start_go) begin
            rd_idx    <= base_index;
            remaining <= len;
            state     <= STREAM;
          end else if (start) begin
            done <= 1'b1;
          end
        end
        STREAM: begin
          if (issue) begin
            rd_idx    <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
            remaining <= remaining - IDX_W'(1);
            if (remaining == IDX_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the outputs below are masked by
  // out_valid, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      fifo_data[wr_ptr] <= ram_rdata;
      fifo_idx[wr_ptr]  <= s1_idx;
      fifo_last[wr_ptr] <= s1_last;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_index = out_valid ? fifo_idx[rd_ptr]  : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_weight_stream_buffer.sv
// Scoreboard bench for weight_stream_buffer: expected beats are queued per command and
// compared on each handshake. Preloads the banks through the load port when WSB_LOAD_EN is set.
module tb_weight_stream_buffer;

  localparam int DATA_W = 18;
  localparam int LANES  = 9;
  localparam int BANKS  = 2;
  localparam int DEPTH  = 42;
  localparam int IDX_W  = 12;
  localparam int WORD_W = LANES * DATA_W;
  localparam int BEAT_W = BANKS * WORD_W;
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

`ifdef WSB_LOAD_EN
  localparam logic LOAD_RDY_EXP = 1'b1;
`else
  localparam logic LOAD_RDY_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic              load_valid = 1'b0;
  logic [IDX_W-1:0]  base_index = '0;
  logic [IDX_W-1:0]  len = '0;
  logic [IDX_W-1:0]  load_addr = '0;
  logic [BANK_W-1:0] load_bank = '0;
  logic [WORD_W-1:0] load_data = '0;
  logic              out_valid, out_last, busy, done, load_ready;
  logic [BEAT_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;

  weight_stream_buffer #(
    .DATA_W(DATA_W), .LANES(LANES), .BANKS(BANKS), .DEPTH(DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_index (base_index),
    .len        (len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_bank  (load_bank),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  logic [WORD_W-1:0] model_mem [BANKS][DEPTH];

  int n_cmp = 0;
  int n_err = 0;
  int tick_no = 0;
  int done_cnt = 0;
  int done_tick = -1;
  int beat_cnt = 0;
  int first_valid_tick = -1;
  int last_hs_tick = -1;
  bit ld_with_start = 1'b0;

  bit                hold_vld = 1'b0;
  logic [BEAT_W-1:0] hold_data;
  logic [IDX_W-1:0]  hold_idx;
  logic              hold_last;

  task automatic check(input string tag, input logic [BEAT_W-1:0] got,
                       input logic [BEAT_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] model_beat(input int i);
    logic [BEAT_W-1:0] v;
    v = '0;
    for (int b = 0; b < BANKS; b++) v[b*WORD_W +: WORD_W] = model_mem[b][i];
    return v;
  endfunction

  // Ready pattern: mode 0 always ready; mode 1 random with a 10-cycle low stretch every 25.
  function automatic logic next_ready(input int mode);
    if (mode == 0) return 1'b1;
    if ((tick_no % 25) >= 15) return 1'b0;
    return ($urandom_range(0, 2) != 0);
  endfunction

  // Samples outputs at the falling edge, then drives inputs for the next rising edge.
  task automatic tick(input logic rdy, input logic st);
    beat_t e;
    @(negedge clk);
    tick_no++;
    if (hold_vld) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, hold_data);
      check("stall_index", out_index, hold_idx);
      check("stall_last", out_last, hold_last);
      hold_vld = 1'b0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_tick = tick_no;
    end
    if (out_valid === 1'b1 && first_valid_tick < 0) first_valid_tick = tick_no;
    out_ready = rdy;
    start     = st;
    if (st && ld_with_start) load_valid = 1'b1;
    if (out_valid === 1'b1 && rdy) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("beat_index", out_index, e.idx);
        check("beat_data", out_data, e.data);
        check("beat_last", out_last, e.last);
      end
      beat_cnt++;
      last_hs_tick = tick_no;
    end else if (out_valid === 1'b1) begin
      hold_vld  = 1'b1;
      hold_data = out_data;
      hold_idx  = out_index;
      hold_last = out_last;
    end
  endtask

  task automatic run_cmd(input int base, input int n, input int mode,
                         input int ignore_at, input string tag);
    int t0, d0, b0, budget;
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.idx  = IDX_W'((base + k) % DEPTH);
      e.data = model_beat((base + k) % DEPTH);
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
    base_index = IDX_W'(base);
    len        = IDX_W'(n);
    d0 = done_cnt;
    b0 = beat_cnt;
    first_valid_tick = -1;
    tick(next_ready(mode), 1'b1);
    t0 = tick_no;
    budget = 0;
    while (done_cnt == d0 && budget < 2000) begin
      if (budget == ignore_at) begin
        base_index = IDX_W'(7);
        len        = IDX_W'(3);
      end
      tick(next_ready(mode), budget == ignore_at);
      if (budget == 0 && n > 0) check({tag, "_load_ready_busy"}, load_ready, 1'b0);
      budget++;
    end
    check({tag, "_done_seen"}, done_cnt - d0, 1);
    check({tag, "_beats"}, beat_cnt - b0, n);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    if (n > 0) begin
      check({tag, "_done_after_last"}, done_tick - last_hs_tick, 1);
      if (mode == 0) begin
        check({tag, "_first_latency"}, first_valid_tick - t0, 3);
        check({tag, "_throughput"}, last_hs_tick - first_valid_tick, n - 1);
      end
    end else begin
      check({tag, "_no_valid"}, first_valid_tick, -1);
      check({tag, "_done_latency"}, done_tick - t0, 1);
    end
    exp_q.delete();
    hold_vld = 1'b0;
  endtask

  task automatic load_word(input int b, input int a, input logic [WORD_W-1:0] d);
    load_bank  = BANK_W'(b);
    load_addr  = IDX_W'(a);
    load_data  = d;
    load_valid = 1'b1;
    tick(1'b1, 1'b0);
    load_valid = 1'b0;
    if (a < DEPTH) model_mem[b][a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, budget;
    for (int b = 0; b < BANKS; b++)
      for (int i = 0; i < DEPTH; i++)
        for (int l = 0; l < LANES; l++)
          model_mem[b][i][l*DATA_W +: DATA_W] = DATA_W'((b << 12) | (i << 4) | l);

    repeat (3) tick(1'b0, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_index", out_index, '0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_load_ready", load_ready, 1'b0);
    reset = 1'b0;
    tick(1'b0, 1'b0);
    check("load_ready_after_rst", load_ready, LOAD_RDY_EXP);

`ifdef WSB_LOAD_EN
    for (int b = 0; b < BANKS; b++)
      for (int i = 0; i < DEPTH; i++)
        load_word(b, i, model_mem[b][i]);
`endif

    run_cmd(0, DEPTH, 0, -1, "basic");
    run_cmd(40, 5, 0, -1, "wrap");
    run_cmd(0, DEPTH, 1, -1, "backpressure");
    run_cmd(17, 0, 0, -1, "len0");
    run_cmd(10, 20, 0, 5, "busy_start");

    // Reset in the middle of a stream, after the 7th beat handshake.
    for (int k = 0; k < DEPTH; k++) exp_q.push_back('{model_beat(k), IDX_W'(k), k == DEPTH - 1});
    base_index = '0;
    len        = IDX_W'(DEPTH);
    b0 = beat_cnt;
    tick(1'b1, 1'b1);
    budget = 0;
    while (beat_cnt - b0 < 7 && budget < 100) begin
      tick(1'b1, 1'b0);
      budget++;
    end
    check("rst_mid_beats", beat_cnt - b0, 7);
    reset     = 1'b1;
    out_ready = 1'b0;
    hold_vld  = 1'b0;
    exp_q.delete();
    tick(1'b0, 1'b0);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    reset = 1'b0;
    tick(1'b1, 1'b0);
    run_cmd(0, 10, 0, -1, "after_reset");

`ifdef WSB_LOAD_EN
    load_word(1, 5, '1);
    load_word(0, DEPTH + 3, '0);
    // Collides with start (start wins) and stays asserted while busy: never accepted.
    load_bank     = BANK_W'(0);
    load_addr     = IDX_W'(6);
    load_data     = '0;
    ld_with_start = 1'b1;
    run_cmd(4, 3, 0, -1, "load");
    load_valid    = 1'b0;
    ld_with_start = 1'b0;
    run_cmd(4, 3, 0, -1, "load_recheck");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
